lift_motion_ctrl: RTL and testbench

Parametrised per-car motion controller for the elevator core. It sits between the direction scheduler and the floor/door logic. It takes the scheduled direction, the current floor and the door state, and produces a one-floor move command with fixed travel and dwell timing. It generalises the previous fixed 7-floor car controller with:
- configurable floor count and floor-index width
- an explicit state machine with an arrival strobe and direction output
- hardware error reporting instead of simulation-only messages

---
 rtl/lift_motion_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lift_motion_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lift_motion_ctrl.sv
// lift_motion_ctrl: per-car motion controller.
// Turns the scheduled direction into a timed one-floor move, followed by a dwell (HOLD) period.
// A door event or an arrival also starts the dwell period.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   enable     in   low freezes state, counter and outputs; arrive is forced to 0
//   door_open  in   door is open
//   cur_floor  in   current floor (1..NUM_FLOORS)
//   dir        in   scheduled direction: 00 STOP, 10 UP, 01 DOWN, 11 illegal
//   next_floor out  target floor while moving, otherwise the held floor
//   move       out  car in motion
//   move_dir   out  direction of the current move (10/01), 00 when idle
//   arrive     out  one-cycle strobe when a move completes
//   busy       out  high in MOVING or HOLD
//   err        out  sticky illegal-command flag
//
// Optional feature: define LIFT_MOTION_ERR_EN to enable the sticky err flag.
// When the macro is not defined, err is tied to 0 and illegal commands are silently ignored.
module lift_motion_ctrl #(
    parameter int unsigned NUM_FLOORS   = 7,
    parameter int unsigned FLOOR_W      = 3,
    parameter int unsigned CLK_PER_MOVE = 1000000000,
    parameter int unsigned CLK_PER_HOLD = 10000000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               door_open,
    input  logic [FLOOR_W-1:0] cur_floor,
    input  logic [1:0]         dir,
    output logic [FLOOR_W-1:0] next_floor,
    output logic               move,
    output logic [1:0]         move_dir,
    output logic               arrive,
    output logic               busy,
    output logic               err
);

    typedef enum logic [1:0] {StIdle, StMoving, StHold} state_e;

    localparam logic [1:0]         DirUp    = 2'b10;
    localparam logic [1:0]         DirDown  = 2'b01;
    localparam logic [1:0]         DirIll   = 2'b11;
    localparam logic [FLOOR_W-1:0] TopFloor = FLOOR_W'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0] OneFloor = FLOOR_W'(1);
    localparam logic [CNT_W-1:0]   MoveLoad = CNT_W'(CLK_PER_MOVE - 1);
    localparam logic [CNT_W-1:0]   HoldLoad = CNT_W'(CLK_PER_HOLD - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FLOOR_W-1:0] next_floor_q, next_floor_d;
    logic               move_q, move_d;
    logic [1:0]         move_dir_q, move_dir_d;
    logic               arrive_q, arrive_d;
    logic               illegal;
`ifdef LIFT_MOTION_ERR_EN
    logic               err_q, err_d;
`endif

    // A floor outside 1..NUM_FLOORS makes every command illegal, including STOP.
    assign illegal = (dir == DirIll) ||
                     (cur_floor == '0) || (cur_floor > TopFloor) ||
                     ((dir == DirUp) && (cur_floor >= TopFloor)) ||
                     ((dir == DirDown) && (cur_floor <= OneFloor));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            next_floor_q <= OneFloor;
            move_q       <= 1'b0;
            move_dir_q   <= 2'b00;
            arrive_q     <= 1'b0;
`ifdef LIFT_MOTION_ERR_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            next_floor_q <= next_floor_d;
            move_q       <= move_d;
            move_dir_q   <= move_dir_d;
            arrive_q     <= arrive_d;
`ifdef LIFT_MOTION_ERR_EN
            err_q        <= err_d;
`endif
        end
    end

    // Next-state logic; with enable low everything holds except the arrive strobe.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        next_floor_d = next_floor_q;
        move_d       = move_q;
        move_dir_d   = move_dir_q;
        arrive_d     = 1'b0;
`ifdef LIFT_MOTION_ERR_EN
        err_d        = err_q;
`endif
        if (enable) begin
            unique case (state_q)
                StIdle: begin
                    if (door_open) begin
                        next_floor_d = cur_floor;
                        cnt_d        = HoldLoad;
                        state_d      = StHold;
                    end else if (illegal) begin
                        next_floor_d = cur_floor;
`ifdef LIFT_MOTION_ERR_EN
                        err_d        = 1'b1;
`endif
                    end else if (dir == DirUp) begin
                        next_floor_d = cur_floor + OneFloor;
                        move_d       = 1'b1;
                        move_dir_d   = DirUp;
                        cnt_d        = MoveLoad;
                        state_d      = StMoving;
                    end else if (dir == DirDown) begin
                        next_floor_d = cur_floor - OneFloor;
                        move_d       = 1'b1;
                        move_dir_d   = DirDown;
                        cnt_d        = MoveLoad;
                        state_d      = StMoving;
                    end else begin
                        next_floor_d = cur_floor;
                    end
                end
                StMoving: begin
                    // door_open and dir are ignored: a started move always completes.
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        move_d     = 1'b0;
                        move_dir_d = 2'b00;
                        arrive_d   = 1'b1;
                        cnt_d      = HoldLoad;
                        state_d    = StHold;
                    end
                end
                StHold: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs
    always_comb begin
        next_floor = next_floor_q;
        move       = move_q;
        move_dir   = move_dir_q;
        arrive     = arrive_q & enable;
        busy       = (state_q != StIdle);
`ifdef LIFT_MOTION_ERR_EN
        err        = err_q;
`else
        err        = 1'b0;
`endif
    end

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// Directed bench for lift_motion_ctrl with NUM_FLOORS=7, CLK_PER_MOVE=4, CLK_PER_HOLD=2.
module tb_lift_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       door_open;
    logic [2:0] cur_floor;
    logic [1:0] dir;
    logic [2:0] next_floor;
    logic       move;
    logic [1:0] move_dir;
    logic       arrive;
    logic       busy;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

`ifdef LIFT_MOTION_ERR_EN
    localparam logic ErrOn = 1'b1;
`else
    localparam logic ErrOn = 1'b0;
`endif

    localparam logic [1:0] UP   = 2'b10;
    localparam logic [1:0] DOWN = 2'b01;
    localparam logic [1:0] STOP = 2'b00;

    lift_motion_ctrl #(
        .NUM_FLOORS  (7),
        .FLOOR_W     (3),
        .CLK_PER_MOVE(4),
        .CLK_PER_HOLD(2),
        .CNT_W       (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .door_open (door_open),
        .cur_floor (cur_floor),
        .dir       (dir),
        .next_floor(next_floor),
        .move      (move),
        .move_dir  (move_dir),
        .arrive    (arrive),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; door_open = 1'b0; cur_floor = 3'd3; dir = STOP;
        step();
        check("rst_next_floor", 32'(next_floor), 32'd1);
        check("rst_move", 32'(move), 32'd0);
        check("rst_move_dir", 32'(move_dir), 32'd0);
        check("rst_arrive", 32'(arrive), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Basic move 3 -> 4
        reset = 1'b0; dir = UP;
        step();
        dir = STOP;
        check("up_next_floor", 32'(next_floor), 32'd4);
        check("up_move_dir", 32'(move_dir), 32'(UP));
        check("up_busy", 32'(busy), 32'd1);
        check("up_move_c1", 32'(move), 32'd1);
        step(); check("up_move_c2", 32'(move), 32'd1);
        step(); check("up_move_c3", 32'(move), 32'd1);
        step(); check("up_move_c4", 32'(move), 32'd1);
        check("up_no_early_arrive", 32'(arrive), 32'd0);
        step();
        cur_floor = 3'd4;
        check("up_move_done", 32'(move), 32'd0);
        check("up_arrive", 32'(arrive), 32'd1);
        check("up_move_dir_clr", 32'(move_dir), 32'd0);
        check("up_hold_floor", 32'(next_floor), 32'd4);
        step();
        check("up_arrive_once", 32'(arrive), 32'd0);
        check("up_hold_busy", 32'(busy), 32'd1);
        step();
        check("up_idle_busy", 32'(busy), 32'd0);

        // Top boundary: UP at floor 7 is illegal
        cur_floor = 3'd7; dir = UP;
        step();
        check("top_move", 32'(move), 32'd0);
        check("top_busy", 32'(busy), 32'd0);
        check("top_next_floor", 32'(next_floor), 32'd7);
        check("top_err", 32'(err), 32'(ErrOn));
        dir = STOP;
        step(); step();
        check("top_err_sticky", 32'(err), 32'(ErrOn));

        // Door has priority over DOWN at floor 5
        cur_floor = 3'd5; dir = DOWN; door_open = 1'b1;
        step();
        door_open = 1'b0;
        check("door_move", 32'(move), 32'd0);
        check("door_busy1", 32'(busy), 32'd1);
        check("door_next_floor", 32'(next_floor), 32'd5);
        step();
        check("door_busy2", 32'(busy), 32'd1);
        check("door_move2", 32'(move), 32'd0);
        step();
        check("door_idle", 32'(busy), 32'd0);
        check("door_idle_move", 32'(move), 32'd0);
        step();
        dir = STOP;
        check("door_then_move", 32'(move), 32'd1);
        check("door_then_floor", 32'(next_floor), 32'd4);
        check("door_then_dir", 32'(move_dir), 32'(DOWN));
        check("door_err_kept", 32'(err), 32'(ErrOn));
        step(); step(); step();
        check("door_move_c4", 32'(move), 32'd1);
        step();
        cur_floor = 3'd4;
        check("door_arrive", 32'(arrive), 32'd1);
        step(); step();
        check("door_back_idle", 32'(busy), 32'd0);

        // Enable stall for 3 cycles mid-move (2 -> 3)
        cur_floor = 3'd2; dir = UP;
        step();
        dir = STOP;
        check("stall_c1", 32'(move), 32'd1);
        step();
        check("stall_c2", 32'(move), 32'd1);
        enable = 1'b0;
        step(); check("stall_frz1", 32'(move), 32'd1);
        step(); check("stall_frz2", 32'(move), 32'd1);
        step(); check("stall_frz3", 32'(move), 32'd1);
        check("stall_frz_arrive", 32'(arrive), 32'd0);
        check("stall_frz_floor", 32'(next_floor), 32'd3);
        enable = 1'b1;
        step(); check("stall_c3", 32'(move), 32'd1);
        step(); check("stall_c4", 32'(move), 32'd1);
        check("stall_no_arrive", 32'(arrive), 32'd0);
        step();
        cur_floor = 3'd3;
        check("stall_done", 32'(move), 32'd0);
        check("stall_arrive", 32'(arrive), 32'd1);
        step();
        check("stall_arrive_once", 32'(arrive), 32'd0);
        step();
        check("stall_idle", 32'(busy), 32'd0);

        // Reset during a move 2 -> 3
        cur_floor = 3'd2; dir = UP;
        step();
        dir = STOP;
        check("rmm_move", 32'(move), 32'd1);
        check("rmm_floor", 32'(next_floor), 32'd3);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rmm_next_floor", 32'(next_floor), 32'd1);
        check("rmm_move0", 32'(move), 32'd0);
        check("rmm_move_dir", 32'(move_dir), 32'd0);
        check("rmm_busy", 32'(busy), 32'd0);
        check("rmm_err", 32'(err), 32'd0);

        // Down chain 2 -> 1, then DOWN at floor 1 is illegal
        cur_floor = 3'd2; dir = DOWN;
        step();
        check("dn_move", 32'(move), 32'd1);
        check("dn_floor", 32'(next_floor), 32'd1);
        check("dn_dir", 32'(move_dir), 32'(DOWN));
        step(); step(); step();
        check("dn_move_c4", 32'(move), 32'd1);
        step();
        cur_floor = 3'd1;
        check("dn_arrive", 32'(arrive), 32'd1);
        step();
        check("dn_hold", 32'(busy), 32'd1);
        step();
        check("dn_idle", 32'(busy), 32'd0);
        step();
        check("dn_ill_move", 32'(move), 32'd0);
        check("dn_ill_busy", 32'(busy), 32'd0);
        check("dn_ill_floor", 32'(next_floor), 32'd1);
        check("dn_ill_err", 32'(err), 32'(ErrOn));
        step();
        check("dn_ill_move2", 32'(move), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
